// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS sequencing controller:
// opcode constants, state encoding, control-field encodings and the
// per-state control word payload.
package multicycle_controller_pkg;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned STATE_W   = 4;
    localparam int unsigned ALUOP_W   = 2;
    localparam int unsigned ALUSRCB_W = 2;
    localparam int unsigned PCSRC_W   = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam state_e STATE_RESET = S_FETCH;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [ALUSRCB_W-1:0] {
        SRCB_REGB  = 2'b00,
        SRCB_FOUR  = 2'b01,
        SRCB_IMM   = 2'b10,
        SRCB_IMMSH = 2'b11
    } alusrcb_e;

    typedef enum logic [PCSRC_W-1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_e;

    // Moore control word produced for each state
    typedef struct packed {
        logic     iord;
        logic     memwrite;
        logic     irwrite;
        logic     regdst;
        logic     memtoreg;
        logic     regwrite;
        logic     alusrca;
        alusrcb_e alusrcb;
        aluop_e   aluop;
        pcsrc_e   pcsrc;
        logic     pcwrite;
        logic     branch;
    } ctrl_t;

    // True for every opcode the sequencer knows how to execute
    function automatic logic op_supported(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> control word decoder.
// Ports:
//   state_i     : current sequencer state
//   mem_ready_i : memory handshake, qualifies the fetch-complete writes
//   ctrl_o      : control word including pcwrite and branch qualifiers
module mc_output_decode
    import multicycle_controller_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.alusrcb = SRCB_FOUR;
                ctrl_o.irwrite = mem_ready_i;
                ctrl_o.pcwrite = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alusrcb = SRCB_IMMSH;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            // Strobe stays up for the whole wait so memory sees a stable request
            S_MEMWR: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
                ctrl_o.branch  = 1'b1;
            end
            S_ADDIWB: begin
                ctrl_o.regwrite = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pcsrc   = PCSRC_JUMP;
                ctrl_o.pcwrite = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing control unit for the multicycle MIPS datapath.
// Ports:
//   clk_i, reset_i (sync, active-high)
//   op_i        : opcode from the instruction register
//   zero_i      : ALU zero flag, used in BRANCH
//   mem_ready_i : memory completes the current access this cycle
//   iord_o .. pcsrc_o : per-state Moore control word
//   pcen_o      : PC enable (pcwrite | branch & zero)
//   retire_o    : pulse on the last cycle of each instruction
//   illegal_o   : pulse when DECODE sees an unsupported opcode
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [OP_W-1:0]      op_i,
    input  logic                 zero_i,
    input  logic                 mem_ready_i,
    output logic                 iord_o,
    output logic                 memwrite_o,
    output logic                 irwrite_o,
    output logic                 regdst_o,
    output logic                 memtoreg_o,
    output logic                 regwrite_o,
    output logic                 alusrca_o,
    output logic [ALUSRCB_W-1:0] alusrcb_o,
    output logic [ALUOP_W-1:0]   aluop_o,
    output logic [PCSRC_W-1:0]   pcsrc_o,
    output logic                 pcen_o,
    output logic                 retire_o,
    output logic                 illegal_o
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;
    logic   bad_op_c;
    logic   last_cycle_c;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= STATE_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:   if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                unique case (op_i)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready_i) state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_output_decode u_output_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready_i),
        .ctrl_o      (ctrl)
    );

    // Illegal opcodes retire in DECODE without touching any state
    assign bad_op_c = (state_q == S_DECODE) && !op_supported(op_i);

    // Final cycle of an instruction; a MEMWR wait cycle is not the last one
    always_comb begin
        last_cycle_c = 1'b0;
        unique case (state_q)
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: last_cycle_c = 1'b1;
            S_MEMWR:  last_cycle_c = mem_ready_i;
            S_DECODE: last_cycle_c = bad_op_c;
            default:  last_cycle_c = 1'b0;
        endcase
    end

    // Write enables and pulses are suppressed while reset is held
    assign iord_o     = ctrl.iord;
    assign memwrite_o = ctrl.memwrite & ~reset_i;
    assign irwrite_o  = ctrl.irwrite  & ~reset_i;
    assign regdst_o   = ctrl.regdst;
    assign memtoreg_o = ctrl.memtoreg;
    assign regwrite_o = ctrl.regwrite & ~reset_i;
    assign alusrca_o  = ctrl.alusrca;
    assign alusrcb_o  = ctrl.alusrcb;
    assign aluop_o    = ctrl.aluop;
    assign pcsrc_o    = ctrl.pcsrc;
    assign pcen_o     = (ctrl.pcwrite | (ctrl.branch & zero_i)) & ~reset_i;
    assign retire_o   = last_cycle_c & ~reset_i;
    assign illegal_o  = bad_op_c & ~reset_i;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is expanded
// into its expected cycle-by-cycle control words, then played against the DUT.
module tb_multicycle_controller;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       retire;
        logic       illegal;
    } cw_t;

    typedef struct packed {
        cw_t        exp;
        cw_t        mask;
        logic       mr;
        logic       z;
        logic [5:0] op;
        logic       rst;
    } step_t;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [5:0] op_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       iord_o, memwrite_o, irwrite_o, regdst_o, memtoreg_o, regwrite_o, alusrca_o;
    logic [1:0] alusrcb_o, aluop_o, pcsrc_o;
    logic       pcen_o, retire_o, illegal_o;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_instr = 0;
    step_t plan[$];
    string plan_nm[$];
    int    lat_q[$];
    int    lat_cnt = 0;
    cw_t   FULL;
    cw_t   RSTM;

    always #5 clk_i = ~clk_i;

    multicycle_controller dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .op_i        (op_i),
        .zero_i      (zero_i),
        .mem_ready_i (mem_ready_i),
        .iord_o      (iord_o),
        .memwrite_o  (memwrite_o),
        .irwrite_o   (irwrite_o),
        .regdst_o    (regdst_o),
        .memtoreg_o  (memtoreg_o),
        .regwrite_o  (regwrite_o),
        .alusrca_o   (alusrca_o),
        .alusrcb_o   (alusrcb_o),
        .aluop_o     (aluop_o),
        .pcsrc_o     (pcsrc_o),
        .pcen_o      (pcen_o),
        .retire_o    (retire_o),
        .illegal_o   (illegal_o)
    );

    // Instruction latency as seen from the DUT: cycles from first FETCH to retire
    always @(negedge clk_i) begin
        if (reset_i) begin
            lat_cnt = 0;
        end else begin
            lat_cnt = lat_cnt + 1;
            if (retire_o) begin
                lat_q.push_back(lat_cnt);
                lat_cnt = 0;
            end
        end
    end

    // Expected control word for one named phase of an instruction
    function automatic cw_t w(input string ph, input logic f);
        cw_t c = '0;
        case (ph)
            "fetch":   begin c.alusrcb = 2'b01; c.irwrite = f; c.pcen = f; end
            "decode":  c.alusrcb = 2'b11;
            "illegal": begin c.alusrcb = 2'b11; c.illegal = 1'b1; c.retire = 1'b1; end
            "memadr", "addiex": begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            "memrd":   c.iord = 1'b1;
            "memwb":   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; c.retire = 1'b1; end
            "memwr":   begin c.iord = 1'b1; c.memwrite = 1'b1; c.retire = f; end
            "execute": begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            "aluwb":   begin c.regdst = 1'b1; c.regwrite = 1'b1; c.retire = 1'b1; end
            "branch":  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01;
                             c.pcen = f; c.retire = 1'b1; end
            "addiwb":  begin c.regwrite = 1'b1; c.retire = 1'b1; end
            "jump":    begin c.pcsrc = 2'b10; c.pcen = 1'b1; c.retire = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_supported(input logic [5:0] op);
        return op == T_RTYPE || op == T_LW || op == T_SW ||
               op == T_BEQ || op == T_ADDI || op == T_J;
    endfunction

    function automatic logic [5:0] rand_op();
        return 6'($urandom);
    endfunction

    task automatic add(input string nm, input cw_t e, input cw_t m, input logic mr,
                       input logic z, input logic [5:0] op, input logic rst);
        step_t s;
        s.exp = e; s.mask = m; s.mr = mr; s.z = z; s.op = op; s.rst = rst;
        plan.push_back(s);
        plan_nm.push_back(nm);
    endtask

    // Expand one instruction into its expected cycles
    task automatic plan_instr(input logic [5:0] op, input int fwait, input int mwait, input logic z);
        logic r;
        n_instr++;
        for (int i = 0; i < fwait; i++)
            add("fetch_wait", w("fetch", 1'b0), FULL, 1'b0, 1'($urandom), rand_op(), 1'b0);
        add("fetch", w("fetch", 1'b1), FULL, 1'b1, 1'($urandom), rand_op(), 1'b0);
        r = 1'($urandom);
        if (!is_supported(op)) begin
            add("illegal", w("illegal", 1'b0), FULL, r, 1'($urandom), op, 1'b0);
            return;
        end
        add("decode", w("decode", 1'b0), FULL, r, 1'($urandom), op, 1'b0);
        case (op)
            T_LW: begin
                add("memadr", w("memadr", 1'b0), FULL, 1'($urandom), 1'($urandom), op, 1'b0);
                for (int i = 0; i < mwait; i++)
                    add("memrd_wait", w("memrd", 1'b0), FULL, 1'b0, 1'($urandom), op, 1'b0);
                add("memrd", w("memrd", 1'b0), FULL, 1'b1, 1'($urandom), op, 1'b0);
                add("memwb", w("memwb", 1'b0), FULL, 1'($urandom), 1'($urandom), op, 1'b0);
            end
            T_SW: begin
                add("memadr", w("memadr", 1'b0), FULL, 1'($urandom), 1'($urandom), op, 1'b0);
                for (int i = 0; i < mwait; i++)
                    add("memwr_wait", w("memwr", 1'b0), FULL, 1'b0, 1'($urandom), op, 1'b0);
                add("memwr", w("memwr", 1'b1), FULL, 1'b1, 1'($urandom), op, 1'b0);
            end
            T_RTYPE: begin
                add("execute", w("execute", 1'b0), FULL, 1'($urandom), 1'($urandom), op, 1'b0);
                add("aluwb", w("aluwb", 1'b0), FULL, 1'($urandom), 1'($urandom), op, 1'b0);
            end
            T_ADDI: begin
                add("addiex", w("addiex", 1'b0), FULL, 1'($urandom), 1'($urandom), op, 1'b0);
                add("addiwb", w("addiwb", 1'b0), FULL, 1'($urandom), 1'($urandom), op, 1'b0);
            end
            T_BEQ: add("branch", w("branch", z), FULL, 1'($urandom), z, op, 1'b0);
            default: add("jump", w("jump", 1'b0), FULL, 1'($urandom), 1'($urandom), op, 1'b0);
        endcase
    endtask

    task automatic plan_reset(input int n);
        for (int i = 0; i < n; i++)
            add("reset", '0, RSTM, 1'($urandom), 1'($urandom), rand_op(), 1'b1);
    endtask

    task automatic check(input string nm, input int idx, input cw_t e, input cw_t m);
        cw_t got;
        got = {iord_o, memwrite_o, irwrite_o, regdst_o, memtoreg_o, regwrite_o, alusrca_o,
               alusrcb_o, aluop_o, pcsrc_o, pcen_o, retire_o, illegal_o};
        n_tests++;
        if ((got & m) !== (e & m)) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h (mask %h)", nm, idx, got, e, m);
        end
    endtask

    task automatic run_plan();
        for (int i = 0; i < plan.size(); i++) begin
            reset_i     = plan[i].rst;
            mem_ready_i = plan[i].mr;
            zero_i      = plan[i].z;
            op_i        = plan[i].op;
            @(negedge clk_i);
            check(plan_nm[i], i, plan[i].exp, plan[i].mask);
            @(posedge clk_i);
            #1;
        end
        plan.delete();
        plan_nm.delete();
    endtask

    initial begin
        int exp_lat[9];
        logic [5:0] op;
        exp_lat = '{5, 3, 3, 7, 6, 2, 4, 3, 4};
        FULL = '1;
        RSTM = '0;
        RSTM.irwrite = 1'b1; RSTM.memwrite = 1'b1; RSTM.regwrite = 1'b1;
        RSTM.pcen = 1'b1; RSTM.retire = 1'b1; RSTM.illegal = 1'b1;
        reset_i = 1'b1; mem_ready_i = 1'b0; zero_i = 1'b0; op_i = '0;

        // Directed scenarios with hand-known latencies
        plan_reset(2);
        plan_instr(T_LW,    0, 0, 1'b0);
        plan_instr(T_BEQ,   0, 0, 1'b1);
        plan_instr(T_BEQ,   0, 0, 1'b0);
        plan_instr(T_SW,    0, 3, 1'b0);
        plan_instr(T_RTYPE, 2, 0, 1'b0);
        plan_instr(6'b111111, 0, 0, 1'b0);
        plan_instr(T_ADDI,  0, 0, 1'b0);
        plan_instr(T_J,     0, 0, 1'b0);
        plan_instr(T_SW,    0, 0, 1'b0);
        run_plan();

        // Reset while an R-type is in EXECUTE aborts it without a register write
        add("fetch", w("fetch", 1'b1), FULL, 1'b1, 1'b0, rand_op(), 1'b0);
        add("decode", w("decode", 1'b0), FULL, 1'b1, 1'b0, T_RTYPE, 1'b0);
        add("execute", w("execute", 1'b0), FULL, 1'b1, 1'b0, T_RTYPE, 1'b0);
        plan_reset(1);
        plan_instr(T_ADDI, 0, 0, 1'b0);
        run_plan();

        // Randomised instruction stream
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 6))
                0: op = T_RTYPE;
                1: op = T_LW;
                2: op = T_SW;
                3: op = T_BEQ;
                4: op = T_ADDI;
                5: op = T_J;
                default: begin
                    op = rand_op();
                    while (is_supported(op)) op = rand_op();
                end
            endcase
            plan_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
        end
        run_plan();

        // Pin the directed latencies to hand-computed cycle counts
        n_tests++;
        if (lat_q.size() != n_instr) begin
            n_fail++;
            $display("FAIL retire_count: got %0d expected %0d", lat_q.size(), n_instr);
        end
        for (int i = 0; i < 9; i++) begin
            n_tests++;
            if (i >= lat_q.size()) begin
                n_fail++;
                $display("FAIL latency_%0d: missing, expected %0d", i, exp_lat[i]);
            end else if (lat_q[i] != exp_lat[i]) begin
                n_fail++;
                $display("FAIL latency_%0d: got %0d expected %0d", i, lat_q[i], exp_lat[i]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
